// File: rtl/dvi_tmds_gearbox.sv
// Multi-lane TMDS word-to-slice gearbox. Buffers full symbols in a small FIFO and
// presents one OUT_W-bit slice per lane per cycle, inserting idle symbols on underrun.
module dvi_tmds_gearbox #(
  parameter int N_CH      = 3,
  parameter int IN_W      = 10,
  parameter int OUT_W     = 5,
  parameter int DEPTH     = 4,
  parameter int PRIME     = 2,
  parameter int MSB_FIRST = 0,
  localparam int RATIO    = IN_W / OUT_W,
  localparam int LW       = $clog2(DEPTH + 1)
) (
  input  logic                   gclk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [N_CH*IN_W-1:0]   s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [N_CH*IN_W-1:0]   idle_data,
  output logic [N_CH*OUT_W-1:0]  dout,
  output logic                   running,
  output logic [LW-1:0]          level,
  output logic [15:0]            underrun_cnt
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PHW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int WW  = N_CH * IN_W;
  localparam int DW  = N_CH * OUT_W;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   mem_q [DEPTH];
  logic [WW-1:0]   mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [PHW-1:0]  phase_q, phase_d;
  logic [WW-1:0]   word_q, word_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [15:0]     ucnt_q, ucnt_d;
  logic            push, pop;
  logic [WW-1:0]   src;
  int              sidx;

  assign s_ready      = (state_q != ST_IDLE) && (level_q < LW'(DEPTH));
  assign push         = s_valid && s_ready;
  assign running      = (state_q == ST_RUN);
  assign level        = level_q;
  assign dout         = dout_q;
  assign underrun_cnt = ucnt_q;

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    phase_d  = phase_q;
    word_d   = word_q;
    dout_d   = dout_q;
    ucnt_d   = ucnt_q;
    pop      = 1'b0;
    src      = word_q;
    sidx     = 0;

    if (!enable) begin
      // Dropping enable abandons any partly sent word and flushes the buffer.
      state_d  = ST_IDLE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      phase_d  = '0;
      dout_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
          ucnt_d  = '0;
        end
        ST_FILL: begin
          if (level_q >= LW'(PRIME)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (phase_q == '0) begin
            if (level_q != '0) begin
              pop = 1'b1;
              src = mem_q[rd_ptr_q];
            end else begin
              src = idle_data;
              if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
            end
            word_d = src;
          end
          sidx = (MSB_FIRST != 0) ? (RATIO - 1 - int'(phase_q)) : int'(phase_q);
          for (int i = 0; i < N_CH; i++) begin
            dout_d[i*OUT_W +: OUT_W] = src[i*IN_W + sidx*OUT_W +: OUT_W];
          end
          phase_d = (phase_q == PHW'(RATIO - 1)) ? '0 : phase_q + PHW'(1);
        end
        default: state_d = ST_IDLE;
      endcase

      if (push) begin
        mem_d[wr_ptr_q] = s_data;
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge gclk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      phase_q  <= '0;
      word_q   <= '0;
      dout_q   <= '0;
      ucnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      phase_q  <= phase_d;
      word_q   <= word_d;
      dout_q   <= dout_d;
      ucnt_q   <= ucnt_d;
    end
    // Storage is qualified by the pointers, so it needs no reset.
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_dvi_tmds_gearbox.sv
// Randomized self-checking bench for dvi_tmds_gearbox against a queue-based
// behavioural model; two instances cover both slice orders.
module tb_dvi_tmds_gearbox;

  localparam int N_CH  = 3;
  localparam int IN_W  = 10;
  localparam int OUT_W = 5;
  localparam int DEPTH = 4;
  localparam int PRIME = 2;
  localparam int RATIO = IN_W / OUT_W;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int WW    = N_CH * IN_W;
  localparam int DW    = N_CH * OUT_W;
  localparam int VW    = 2*DW + 1 + LW + 1 + 16;

  logic           gclk = 1'b0;
  logic           reset_n, enable, s_valid;
  logic [WW-1:0]  s_data, idle_data;
  logic           s_ready, s_ready_m, running, running_m;
  logic [DW-1:0]  dout, dout_m;
  logic [LW-1:0]  level, level_m;
  logic [15:0]    underrun_cnt, underrun_cnt_m;

  int checks = 0;
  int errors = 0;

  // Behavioural model: 0 = IDLE, 1 = FILL, 2 = RUN
  int             m_st;
  logic [WW-1:0]  m_q[$];
  int             m_phase;
  logic [WW-1:0]  m_word;
  logic [DW-1:0]  m_dout, m_dout_m;
  int             m_ucnt;

  always #5 gclk = ~gclk;

  dvi_tmds_gearbox #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
                     .PRIME(PRIME), .MSB_FIRST(0)) u_dut (
    .gclk(gclk), .reset_n(reset_n), .enable(enable), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .idle_data(idle_data), .dout(dout),
    .running(running), .level(level), .underrun_cnt(underrun_cnt));

  dvi_tmds_gearbox #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
                     .PRIME(PRIME), .MSB_FIRST(1)) u_dut_m (
    .gclk(gclk), .reset_n(reset_n), .enable(enable), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready_m), .idle_data(idle_data), .dout(dout_m),
    .running(running_m), .level(level_m), .underrun_cnt(underrun_cnt_m));

  function automatic logic [DW-1:0] slice_of(input logic [WW-1:0] w, input int k, input bit msb);
    logic [IN_W-1:0]  lane;
    logic [OUT_W-1:0] part;
    int idx;
    slice_of = '0;
    idx = msb ? (RATIO - 1 - k) : k;
    for (int i = 0; i < N_CH; i++) begin
      lane = IN_W'(w >> (i*IN_W));
      part = OUT_W'(lane >> (idx*OUT_W));
      slice_of[i*OUT_W +: OUT_W] = part;
    end
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic rdy;
    rdy = (m_st != 0) && (m_q.size() < DEPTH);
    model_vec = {m_dout, m_dout_m, (m_st == 2), LW'(m_q.size()), rdy, 16'(m_ucnt)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    dut_vec = {dout, dout_m, running, level, s_ready, underrun_cnt};
  endfunction

  function automatic logic [WW-1:0] rand_word();
    rand_word = WW'({$urandom(), $urandom()});
  endfunction

  // Advance model and DUT by one clock edge using the currently driven inputs.
  task automatic tick();
    bit acc;
    acc = s_valid && (m_st != 0) && (m_q.size() < DEPTH);
    if (!reset_n) begin
      m_st = 0; m_q.delete(); m_phase = 0; m_word = '0;
      m_dout = '0; m_dout_m = '0; m_ucnt = 0;
    end else if (!enable) begin
      m_st = 0; m_q.delete(); m_phase = 0; m_dout = '0; m_dout_m = '0;
    end else begin
      if (m_st == 2) begin
        if (m_phase == 0) begin
          if (m_q.size() > 0) m_word = m_q.pop_front();
          else begin
            m_word = idle_data;
            if (m_ucnt < 65535) m_ucnt++;
          end
        end
        m_dout   = slice_of(m_word, m_phase, 1'b0);
        m_dout_m = slice_of(m_word, m_phase, 1'b1);
        m_phase  = (m_phase + 1) % RATIO;
      end else if (m_st == 1) begin
        if (m_q.size() >= PRIME) m_st = 2;
      end else begin
        m_st = 1;
        m_ucnt = 0;
      end
      if (acc) m_q.push_back(s_data);
    end
    @(posedge gclk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; s_valid = 1'b1;
    s_data = rand_word(); idle_data = rand_word();
    repeat (3) begin
      tick();
      checks++;
      if (dut_vec() !== '0) begin
        errors++;
        $display("FAIL reset_outputs got %h exp 0", dut_vec());
      end
    end
    reset_n = 1'b1; enable = 1'b0;
    repeat (5) begin
      tick();
      checks++;
      if (dut_vec() !== '0 || s_ready_m !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs got %h s_ready_m %b exp 0", dut_vec(), s_ready_m);
      end
    end
  endtask

  task automatic test_ordering();
    enable = 1'b1; s_valid = 1'b1;
    s_data = {N_CH{10'h3A5}}; idle_data = rand_word();
    repeat (30) begin
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL order_vec got %h exp %h", dut_vec(), model_vec());
      end
      if (running && dout != '0) begin
        checks++;
        if (!((dout[4:0] == 5'h05 && dout_m[4:0] == 5'h1D) ||
              (dout[4:0] == 5'h1D && dout_m[4:0] == 5'h05))) begin
          errors++;
          $display("FAIL order_const got dout %h dout_m %h exp 05/1D pairing", dout[4:0], dout_m[4:0]);
        end
      end
    end
    checks++;
    if (underrun_cnt !== 16'h0) begin
      errors++;
      $display("FAIL order_ucnt got %h exp 0", underrun_cnt);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_underrun();
    enable = 1'b1; s_valid = 1'b0; idle_data = {N_CH{10'h2AB}};
    tick();
    s_valid = 1'b1;
    s_data = rand_word(); tick();
    s_data = rand_word(); tick();
    s_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL underrun_vec got %h exp %h", dut_vec(), model_vec());
      end
      if (c >= 10) begin
        checks++;
        if (running !== 1'b1 ||
            !((dout[4:0] == 5'h0B && dout_m[4:0] == 5'h15) ||
              (dout[4:0] == 5'h15 && dout_m[4:0] == 5'h0B))) begin
          errors++;
          $display("FAIL underrun_idle got run %b dout %h dout_m %h exp 1 0B/15", running, dout[4:0], dout_m[4:0]);
        end
      end
    end
    checks++;
    if (underrun_cnt < 16'd8) begin
      errors++;
      $display("FAIL underrun_count got %0d exp >= 8", underrun_cnt);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [9:0] cnt, exp_n;
    logic [4:0] lo;
    bit have_lo, acc;
    cnt = 10'h100; exp_n = 10'h100; have_lo = 0;
    enable = 1'b1; s_valid = 1'b1; idle_data = rand_word();
    s_data = {20'($urandom()), cnt};
    for (int c = 0; c < 50; c++) begin
      acc = s_valid && s_ready;
      tick();
      if (acc) cnt++;
      s_data = {20'($urandom()), cnt};
      checks++;
      if (dut_vec() !== model_vec() || level > LW'(DEPTH) || (level == LW'(DEPTH) && s_ready)) begin
        errors++;
        $display("FAIL bp_vec got %h exp %h", dut_vec(), model_vec());
      end
      if (m_st == 2 && m_phase == 1) begin
        lo = dout[4:0]; have_lo = 1;
      end else if (m_st == 2 && m_phase == 0 && have_lo) begin
        checks++;
        if ({dout[4:0], lo} !== exp_n) begin
          errors++;
          $display("FAIL bp_order got %h exp %h", {dout[4:0], lo}, exp_n);
        end
        exp_n++;
        have_lo = 0;
      end
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_disable();
    int n;
    int held;
    logic [WW-1:0] w_new;
    enable = 1'b1; s_valid = 1'b0; idle_data = rand_word();
    tick();
    s_valid = 1'b1;
    s_data = rand_word(); tick();
    s_data = rand_word(); tick();
    s_valid = 1'b0;
    n = 0;
    while (!(m_ucnt >= 2 && m_st == 2 && m_phase == 1) && n < 40) begin
      tick();
      n++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL dis_vec got %h exp %h", dut_vec(), model_vec());
      end
    end
    if (n >= 40) begin
      errors++;
      $display("FAIL dis_timeout got %0d cycles exp < 40", n);
    end
    held = m_ucnt;
    enable = 1'b0;
    tick();
    checks++;
    if (dout !== '0 || dout_m !== '0 || level !== '0 || running !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL dis_flush got dout %h level %0d run %b rdy %b exp 0", dout, level, running, s_ready);
    end
    checks++;
    if (underrun_cnt !== 16'(held)) begin
      errors++;
      $display("FAIL dis_ucnt_hold got %0d exp %0d", underrun_cnt, held);
    end
    w_new = rand_word();
    enable = 1'b1; s_valid = 1'b1; s_data = w_new;
    tick();
    checks++;
    if (underrun_cnt !== 16'h0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reen_clear got ucnt %0d rdy %b exp 0 1", underrun_cnt, s_ready);
    end
    tick();
    s_data = rand_word();
    n = 0;
    while (!(m_st == 2 && m_phase == 1) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20 || dout !== {w_new[24:20], w_new[14:10], w_new[4:0]}) begin
      errors++;
      $display("FAIL reen_first got %h exp %h", dout, {w_new[24:20], w_new[14:10], w_new[4:0]});
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset_n   = ($urandom_range(199) != 0);
      enable    = ($urandom_range(39) != 0);
      s_valid   = ($urandom_range(9) < 6);
      s_data    = rand_word();
      idle_data = rand_word();
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL rand_vec cycle %0d got %h exp %h", c, dut_vec(), model_vec());
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; s_valid = 1'b0;
    s_data = '0; idle_data = '0;
    m_st = 0; m_phase = 0; m_word = '0; m_dout = '0; m_dout_m = '0; m_ucnt = 0;
    test_reset();
    test_ordering();
    test_underrun();
    test_backpressure();
    test_disable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
